// File: rtl/key_event_decoder_pkg.sv
// Shared types and helpers for the key event decoder: FSM state encoding,
// event pulse bundle and ms-to-cycle conversion.
package key_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_LONG,
    ST_WAIT2,
    ST_WAIT_REL
  } state_e;

  typedef struct packed {
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic double_click;
  } events_t;

  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return ms * (clk_freq / 1000);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key stream in, gesture events out. master = key source / event consumer,
// slave = decoder.
interface key_event_decoder_if;
  logic key_flag;
  logic key_value;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic double_click;
  logic key_hold;

  modport master (
    output key_flag, key_value,
    input  short_press, long_press, repeat_pulse, double_click, key_hold
  );

  modport slave (
    input  key_flag, key_value,
    output short_press, long_press, repeat_pulse, double_click, key_hold
  );
endinterface

// File: rtl/key_event_decoder_ms_tick_gen.sv
// Millisecond tick: one-cycle pulse every CLK_FREQ/1000 cycles, restarted by clr_i
// so the first tick after a restart lands exactly one ms later.
module ms_tick_gen
  import key_event_decoder_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int Div  = ms_to_cycles(CLK_FREQ, 1);
  localparam int CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick_o = (cnt_q == CntW'(Div - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies the debounced key stream into short/long/repeat/double-click pulses.
// Timer restarts on every state change, so each threshold counts from state entry.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  key_event_decoder_if.slave  key_if
);

  localparam int MsMax = max3(LONG_MS, DCLICK_MS, REPEAT_MS);
  localparam int MsW   = $clog2(MsMax + 1);

  state_e           state_q, state_d;
  logic [MsW-1:0]   ms_q, ms_d;
  events_t          ev_q, ev_d;
  logic             hold_q, hold_d;

  logic press_ev, rel_ev;
  logic ms_tick, timer_clr, restart;
  logic long_hit, dclick_hit, repeat_hit;

  assign press_ev = key_if.key_flag & ~key_if.key_value;
  assign rel_ev   = key_if.key_flag &  key_if.key_value;

  // A threshold is hit on the tick that would take the counter to N ms.
  assign long_hit   = ms_tick && (ms_q == MsW'(LONG_MS - 1));
  assign dclick_hit = ms_tick && (ms_q == MsW'(DCLICK_MS - 1));
  assign repeat_hit = ms_tick && (ms_q == MsW'(REPEAT_MS - 1));

  ms_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr_i   (timer_clr),
    .tick_o  (ms_tick)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ev_d    = '0;
    restart = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_ev) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (rel_ev) begin
          state_d = ST_WAIT2;
        end else if (long_hit) begin
          state_d         = ST_LONG;
          ev_d.long_press = 1'b1;
        end
      end
      ST_LONG: begin
        if (rel_ev) begin
          state_d = ST_IDLE;
        end else if (repeat_hit) begin
          ev_d.repeat_pulse = 1'b1;
          restart           = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (press_ev) begin
          state_d           = ST_WAIT_REL;
          ev_d.double_click = 1'b1;
        end else if (dclick_hit) begin
          state_d          = ST_IDLE;
          ev_d.short_press = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (rel_ev) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Untimed states keep the timer parked at zero so it can never wrap.
  assign timer_clr = restart || (state_d != state_q) ||
                     !(state_q inside {ST_PRESS1, ST_LONG, ST_WAIT2});

  always_comb begin
    ms_d = ms_q;
    if (timer_clr)    ms_d = '0;
    else if (ms_tick) ms_d = ms_q + MsW'(1);
  end

  assign hold_d = (state_d inside {ST_PRESS1, ST_LONG, ST_WAIT_REL});

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      ms_q    <= '0;
      ev_q    <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      ev_q    <= ev_d;
      hold_q  <= hold_d;
    end
  end

  assign key_if.short_press  = ev_q.short_press;
  assign key_if.long_press   = ev_q.long_press;
  assign key_if.repeat_pulse = ev_q.repeat_pulse;
  assign key_if.double_click = ev_q.double_click;
  assign key_if.key_hold     = hold_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench: directed gesture table, reset/redundant-strobe sequences and
// random key streams, all checked cycle-by-cycle against a timestamp-based model.
module tb_key_event_decoder;

  localparam int CLK_FREQ  = 10_000;
  localparam int LONG_MS   = 20;
  localparam int DCLICK_MS = 10;
  localparam int REPEAT_MS = 5;
  localparam int CPM       = CLK_FREQ / 1000;
  localparam int LONG_C    = LONG_MS * CPM;
  localparam int DC_C      = DCLICK_MS * CPM;
  localparam int REP_C     = REPEAT_MS * CPM;

  localparam int M_IDLE = 0, M_FIRST = 1, M_LONG = 2, M_GAP = 3, M_SECOND = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  key_event_decoder_if kif ();

  key_event_decoder #(
    .CLK_FREQ  (CLK_FREQ),
    .LONG_MS   (LONG_MS),
    .DCLICK_MS (DCLICK_MS),
    .REPEAT_MS (REPEAT_MS)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_if  (kif.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cur_val = 1'b1;

  // Reference model: the gesture phase plus the cycle the phase's timing began.
  int m_mode = M_IDLE;
  int m_t0   = 0;

  int n_short, n_long, n_rep, n_dc, n_hold;
  int t_short, t_long, t_rep, t_dc;

  typedef struct {
    string name;
    int    hold1, gap, hold2;
    int    e_short, e_long, e_rep, e_dc, e_hold;
    int    at_short, at_long, at_rep, at_dc;
  } row_t;

  row_t rows[5];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    n_short = 0; n_long = 0; n_rep = 0; n_dc = 0; n_hold = 0;
    t_short = -1; t_long = -1; t_rep = -1; t_dc = -1;
  endtask

  // One clock: drive inputs, predict next-cycle outputs, sample after the edge.
  task automatic step(input bit f);
    bit press, rel, e_s, e_l, e_r, e_d, e_h;
    int el;
    logic [4:0] got;
    @(negedge sys_clk);
    kif.key_flag  = f;
    kif.key_value = cur_val;
    press = f && !cur_val;
    rel   = f && cur_val;
    el    = cyc - m_t0;
    {e_s, e_l, e_r, e_d} = 4'b0;
    case (m_mode)
      M_IDLE:   if (press) begin m_mode = M_FIRST; m_t0 = cyc; end
      M_FIRST:  if (rel) begin m_mode = M_GAP; m_t0 = cyc; end
                else if (el == LONG_C) begin m_mode = M_LONG; m_t0 = cyc; e_l = 1; end
      M_LONG:   if (rel) m_mode = M_IDLE;
                else if (el == REP_C) begin m_t0 = cyc; e_r = 1; end
      M_GAP:    if (press) begin m_mode = M_SECOND; e_d = 1; end
                else if (el == DC_C) begin m_mode = M_IDLE; e_s = 1; end
      default:  if (rel) m_mode = M_IDLE;
    endcase
    e_h = (m_mode == M_FIRST) || (m_mode == M_LONG) || (m_mode == M_SECOND);
    @(posedge sys_clk);
    #1;
    got = {kif.short_press, kif.long_press, kif.repeat_pulse, kif.double_click, kif.key_hold};
    check($sformatf("outputs@%0d", cyc + 1), {27'b0, got}, {27'b0, e_s, e_l, e_r, e_d, e_h});
    if (kif.short_press === 1'b1)  begin n_short++; if (t_short < 0) t_short = cyc + 1; end
    if (kif.long_press === 1'b1)   begin n_long++;  if (t_long  < 0) t_long  = cyc + 1; end
    if (kif.repeat_pulse === 1'b1) begin n_rep++;   if (t_rep   < 0) t_rep   = cyc + 1; end
    if (kif.double_click === 1'b1) begin n_dc++;    if (t_dc    < 0) t_dc    = cyc + 1; end
    if (kif.key_hold === 1'b1) n_hold++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic strobe(input bit v);
    cur_val = v;
    step(1'b1);
  endtask

  task automatic do_reset(input string name);
    @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    kif.key_flag = 1'b0;
    #1;
    check({name, "_outputs_in_reset"},
          {27'b0, kif.short_press, kif.long_press, kif.repeat_pulse, kif.double_click,
           kif.key_hold}, 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    m_mode  = M_IDLE;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_short"}, n_short, 0);
    check({name, "_long"},  n_long,  0);
    check({name, "_rep"},   n_rep,   0);
    check({name, "_dc"},    n_dc,    0);
    check({name, "_hold"},  n_hold,  0);
  endtask

  task automatic run_row(input row_t r);
    int base;
    clear_log();
    base = cyc;
    strobe(1'b0);
    idle(r.hold1 - 1);
    strobe(1'b1);
    if (r.gap > 0) begin
      idle(r.gap - 1);
      strobe(1'b0);
      idle(r.hold2 - 1);
      strobe(1'b1);
    end
    idle(350);
    check({r.name, "_n_short"}, n_short, r.e_short);
    check({r.name, "_n_long"},  n_long,  r.e_long);
    check({r.name, "_n_rep"},   n_rep,   r.e_rep);
    check({r.name, "_n_dc"},    n_dc,    r.e_dc);
    check({r.name, "_n_hold"},  n_hold,  r.e_hold);
    if (r.at_short >= 0) check({r.name, "_t_short"}, t_short - base, r.at_short);
    if (r.at_long  >= 0) check({r.name, "_t_long"},  t_long  - base, r.at_long);
    if (r.at_rep   >= 0) check({r.name, "_t_rep"},   t_rep   - base, r.at_rep);
    if (r.at_dc    >= 0) check({r.name, "_t_dc"},    t_dc    - base, r.at_dc);
  endtask

  initial begin
    int base, gap;
    bit v;

    //           name          h1  gap  h2  sh lg rp dc hold  @sh  @lg  @rp  @dc
    rows[0] = '{"t1_short",    50,  -1,  0, 1, 0, 0, 0,  50, 151,  -1,  -1,  -1};
    rows[1] = '{"t2_long",    320,  -1,  0, 0, 1, 2, 0, 320,  -1, 201, 251,  -1};
    rows[2] = '{"t3_dclick",   30,  40,500, 0, 0, 0, 1, 530,  -1,  -1,  -1,  71};
    rows[3] = '{"t4_rel_edge",200,  -1,  0, 1, 0, 0, 0, 200, 301,  -1,  -1,  -1};
    rows[4] = '{"t4_prs_edge", 50, 100, 20, 0, 0, 0, 1,  70,  -1,  -1,  -1, 151};

    kif.key_flag  = 1'b0;
    kif.key_value = 1'b1;
    #12;
    check("reset_outputs",
          {27'b0, kif.short_press, kif.long_press, kif.repeat_pulse, kif.double_click,
           kif.key_hold}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    idle(5);

    for (int i = 0; i < 5; i++) run_row(rows[i]);

    // Reset mid-hold: key still physically down afterwards, then released.
    strobe(1'b0);
    idle(149);
    do_reset("rst_hold");
    clear_log();
    idle(300);
    strobe(1'b1);
    idle(50);
    check_quiet("rst_hold_after");

    // Reset mid double-click gap.
    strobe(1'b0);
    idle(29);
    strobe(1'b1);
    idle(49);
    do_reset("rst_wait2");
    clear_log();
    idle(200);
    check_quiet("rst_wait2_after");
    run_row(rows[0]);

    // Redundant press strobe, then a redundant release in idle.
    clear_log();
    base = cyc;
    strobe(1'b0);
    idle(29);
    strobe(1'b0);
    idle(29);
    strobe(1'b1);
    idle(150);
    strobe(1'b1);
    idle(150);
    check("t6_n_short", n_short, 1);
    check("t6_t_short", t_short - base, 161);
    check("t6_n_dc",    n_dc, 0);
    check("t6_n_hold",  n_hold, 60);

    // Random key streams with gaps clustered around every threshold.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 4))
        0:       gap = $urandom_range(1, 5);
        1:       gap = $urandom_range(95, 105);
        2:       gap = $urandom_range(195, 205);
        3:       gap = $urandom_range(45, 55);
        default: gap = $urandom_range(300, 400);
      endcase
      idle(gap - 1);
      v = ($urandom_range(0, 3) != 0) ? !cur_val : cur_val;
      strobe(v);
    end
    strobe(1'b1);
    idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
